// File: rtl/poll_sched_pkg.sv
// Shared types and score constants for the motor poll scheduler.
// Provides the FSM state enum and saturating score helpers.
package poll_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_RESP
  } state_t;

  localparam logic [7:0] SCORE_INIT = 8'd128;
  localparam logic [7:0] SCORE_INC  = 8'd1;
  localparam logic [7:0] SCORE_DEC  = 8'd8;
  localparam logic [7:0] SCORE_MAX  = 8'd255;

  function automatic logic [7:0] score_good(
    input logic [7:0] s
  );
    return (s >= SCORE_MAX - SCORE_INC) ? SCORE_MAX
                                        : s + SCORE_INC;
  endfunction

  function automatic logic [7:0] score_bad(
    input logic [7:0] s
  );
    return (s < SCORE_DEC) ? 8'd0 : s - SCORE_DEC;
  endfunction

endpackage

// File: rtl/poll_tick_gen.sv
// Phase-accumulator tick source: one tick per motor slot period.
// Ports: clk, reset, update_frequency_Hz (0 = halted), tick (1-cycle).
module poll_tick_gen
  import poll_sched_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ_HZ    = 50_000_000,
  parameter int unsigned NUMBER_OF_MOTORS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] update_frequency_Hz,
  output logic        tick
);

  localparam logic [39:0] CLK40 = 40'(CLOCK_FREQ_HZ);
  localparam logic [39:0] NM40  = 40'(NUMBER_OF_MOTORS);

  logic [31:0] acc;
  logic [39:0] step;
  logic [39:0] sum;

  always_comb begin
    step = 40'(update_frequency_Hz) * NM40;
    sum  = 40'(acc) + step;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (update_frequency_Hz != '0) begin
        if (sum >= CLK40) begin
          acc  <= 32'(sum - CLK40);
          tick <= 1'b1;
        end else begin
          acc  <= sum[31:0];
        end
      end
    end
  end

endmodule

// File: rtl/motor_poll_scheduler.sv
// Round-robin motor poll scheduler with timeout and link-quality scores.
// Ports: clk, reset, update_frequency_Hz, motor_enable, cmd_valid/ready/motor,
// resp_valid/motor/crc_ok, current_motor, busy, timeout_pulse,
// overrun_count, quality_sel, quality. Optional macro: RETRY_EN.
module motor_poll_scheduler
  import poll_sched_pkg::*;
#(
  parameter int unsigned NUMBER_OF_MOTORS = 8,
  parameter int unsigned CLOCK_FREQ_HZ    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES   = 50_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 update_frequency_Hz,
  input  logic [NUMBER_OF_MOTORS-1:0] motor_enable,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic [7:0]                  cmd_motor,
  input  logic                        resp_valid,
  input  logic [7:0]                  resp_motor,
  input  logic                        resp_crc_ok,
  output logic [7:0]                  current_motor,
  output logic                        busy,
  output logic                        timeout_pulse,
  output logic [15:0]                 overrun_count,
  input  logic [7:0]                  quality_sel,
  output logic [7:0]                  quality
);

  localparam int unsigned IW =
    (NUMBER_OF_MOTORS > 1) ? $clog2(NUMBER_OF_MOTORS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    LAST   = 8'(NUMBER_OF_MOTORS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_d;
  logic          tick;
  logic          pending, pending_d;
  logic          consume;
  logic          cmd_valid_d;
  logic [7:0]    cmd_motor_d, cur_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic          timeout_d;
  logic [15:0]   ovr_d;
  logic          score_we;
  logic [7:0]    score_val, cur_score;
  logic [7:0]    scores [NUMBER_OF_MOTORS];
  logic [7:0]    nxt;
  logic          found;
  logic          hit, tmo;
  int unsigned   idx;
`ifdef RETRY_EN
  logic          retry, retry_d;
`endif

  poll_tick_gen #(
    .CLOCK_FREQ_HZ    (CLOCK_FREQ_HZ),
    .NUMBER_OF_MOTORS (NUMBER_OF_MOTORS)
  ) u_tick (
    .clk                 (clk),
    .reset               (reset),
    .update_frequency_Hz (update_frequency_Hz),
    .tick                (tick)
  );

  assign busy      = (state != IDLE);
  assign cur_score = scores[current_motor[IW-1:0]];

  // Rotating priority search starting one past the current slot.
  always_comb begin
    nxt   = current_motor;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= NUMBER_OF_MOTORS; i++) begin
      idx = 32'(current_motor) + i;
      if (idx >= NUMBER_OF_MOTORS) idx = idx - NUMBER_OF_MOTORS;
      if (!found && motor_enable[IW'(idx)]) begin
        found = 1'b1;
        nxt   = 8'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state;
    cmd_valid_d = cmd_valid;
    cmd_motor_d = cmd_motor;
    cur_d       = current_motor;
    tcnt_d      = tcnt;
    timeout_d   = 1'b0;
    score_we    = 1'b0;
    score_val   = cur_score;
    consume     = 1'b0;
    hit         = resp_valid && (resp_motor == current_motor);
    tmo         = (tcnt == T_LAST);
`ifdef RETRY_EN
    retry_d     = retry;
`endif
    unique case (state)
      IDLE: begin
        if (pending) begin
          consume = 1'b1;
          if (found) begin
            cur_d       = nxt;
            cmd_motor_d = nxt;
            cmd_valid_d = 1'b1;
            state_d     = SEND;
          end
        end
      end
      SEND: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          tcnt_d      = '0;
          state_d     = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (!tmo) tcnt_d = tcnt + 1'b1;
        // A matching response beats a timeout in the same cycle.
        timeout_d = !hit && tmo;
        if (hit && resp_crc_ok) begin
          score_we  = 1'b1;
          score_val = score_good(cur_score);
          state_d   = IDLE;
`ifdef RETRY_EN
          retry_d   = 1'b0;
`endif
        end else if (hit || tmo) begin
`ifdef RETRY_EN
          if (!retry) begin
            retry_d     = 1'b1;
            cmd_valid_d = 1'b1;
            state_d     = SEND;
          end else begin
            retry_d   = 1'b0;
            score_we  = 1'b1;
            score_val = score_bad(cur_score);
            state_d   = IDLE;
          end
`else
          score_we  = 1'b1;
          score_val = score_bad(cur_score);
          state_d   = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // One-deep tick queue: a tick is only lost when one is already waiting.
    pending_d = tick | (pending & ~consume);
    ovr_d     = overrun_count;
    if (tick && pending && !consume && overrun_count != 16'hFFFF)
      ovr_d = overrun_count + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pending       <= 1'b0;
      cmd_valid     <= 1'b0;
      cmd_motor     <= '0;
      current_motor <= LAST;
      tcnt          <= '0;
      timeout_pulse <= 1'b0;
      overrun_count <= '0;
      quality       <= '0;
`ifdef RETRY_EN
      retry         <= 1'b0;
`endif
      for (int i = 0; i < NUMBER_OF_MOTORS; i++)
        scores[i] <= SCORE_INIT;
    end else begin
      state         <= state_d;
      pending       <= pending_d;
      cmd_valid     <= cmd_valid_d;
      cmd_motor     <= cmd_motor_d;
      current_motor <= cur_d;
      tcnt          <= tcnt_d;
      timeout_pulse <= timeout_d;
      overrun_count <= ovr_d;
`ifdef RETRY_EN
      retry         <= retry_d;
`endif
      if (score_we)
        scores[current_motor[IW-1:0]] <= score_val;
      if (32'(quality_sel) < NUMBER_OF_MOTORS)
        quality <= scores[quality_sel[IW-1:0]];
      else
        quality <= '0;
    end
  end

endmodule

// File: tb/tb_motor_poll_scheduler.sv
// Directed testbench for motor_poll_scheduler (4 motors, 1 kHz clock model).
// Scenarios: reset, round robin, masks, hold/overrun, timeout, CRC, retry.
module tb_motor_poll_scheduler;

  localparam int N  = 4;
  localparam int CF = 1000;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] update_frequency_Hz;
  logic [3:0]  motor_enable;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_motor;
  logic        resp_valid;
  logic [7:0]  resp_motor;
  logic        resp_crc_ok;
  logic [7:0]  current_motor;
  logic        busy;
  logic        timeout_pulse;
  logic [15:0] overrun_count;
  logic [7:0]  quality_sel;
  logic [7:0]  quality;

  int vec = 0;
  int bad = 0;
  int got_m [8];
  int got_t [8];
  int ngot;

  always #5 clk = ~clk;

  motor_poll_scheduler #(
    .NUMBER_OF_MOTORS (N),
    .CLOCK_FREQ_HZ    (CF),
    .TIMEOUT_CYCLES   (TO)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .update_frequency_Hz (update_frequency_Hz),
    .motor_enable        (motor_enable),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_motor           (cmd_motor),
    .resp_valid          (resp_valid),
    .resp_motor          (resp_motor),
    .resp_crc_ok         (resp_crc_ok),
    .current_motor       (current_motor),
    .busy                (busy),
    .timeout_pulse       (timeout_pulse),
    .overrun_count       (overrun_count),
    .quality_sel         (quality_sel),
    .quality             (quality)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] f, input logic [3:0] m);
    reset = 1'b1;
    cmd_ready = 1'b0;
    resp_valid = 1'b0;
    resp_motor = '0;
    resp_crc_ok = 1'b0;
    quality_sel = '0;
    update_frequency_Hz = '0;
    motor_enable = m;
    cyc();
    cyc();
    reset = 1'b0;
    update_frequency_Hz = f;
  endtask

  task automatic wait_cv(input int budget, output int n);
    n = 0;
    while (!cmd_valid && n < budget) begin
      cyc();
      n++;
    end
  endtask

  task automatic wait_to(input int budget, output int n);
    n = 0;
    while (!timeout_pulse && n < budget) begin
      cyc();
      n++;
    end
  endtask

  // Steps with cmd_ready high, answering every handshake next cycle.
  task automatic collect(input int n, input int budget);
    logic prev, hs;
    logic [7:0] m;
    ngot = 0;
    for (int i = 0; i < 8; i++) begin
      got_m[i] = -1;
      got_t[i] = -1;
    end
    prev = cmd_valid;
    for (int c = 1; c <= budget && ngot < n; c++) begin
      hs = cmd_valid && cmd_ready;
      m = cmd_motor;
      cyc();
      resp_valid = hs;
      resp_motor = m;
      resp_crc_ok = 1'b1;
      if (cmd_valid && !prev) begin
        got_m[ngot] = int'(cmd_motor);
        got_t[ngot] = c;
        ngot++;
      end
      prev = cmd_valid;
    end
  endtask

  task automatic test_reset();
    do_reset(32'd0, 4'hF);
    reset = 1'b1;
    cyc();
    vec++;
    if ({cmd_valid, busy, timeout_pulse} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 000",
               {cmd_valid, busy, timeout_pulse});
    end
    vec++;
    if (current_motor !== 8'd3 || cmd_motor !== 8'd0) begin
      bad++;
      $display("FAIL reset_idx: got cur %0d cmd %0d want 3 0",
               current_motor, cmd_motor);
    end
    vec++;
    if (overrun_count !== 16'd0 || quality !== 8'd0) begin
      bad++;
      $display("FAIL reset_cnt: got ovr %0d q %0d want 0 0",
               overrun_count, quality);
    end
    reset = 1'b0;
    cyc();
    vec++;
    if (quality !== 8'd128) begin
      bad++;
      $display("FAIL reset_score: got %0d want 128", quality);
    end
  endtask

  task automatic test_round_robin();
    int exp_a [5] = '{0, 1, 2, 3, 0};
    int exp_b [4] = '{1, 3, 1, 3};
    int ov;
    do_reset(32'd25, 4'b1111);
    cmd_ready = 1'b1;
    collect(5, 100);
    for (int i = 0; i < 5; i++) begin
      vec++;
      if (got_m[i] !== exp_a[i]) begin
        bad++;
        $display("FAIL rr_seq[%0d]: got %0d want %0d",
                 i, got_m[i], exp_a[i]);
      end
    end
    for (int i = 1; i < 5; i++) begin
      vec++;
      if (got_t[i] - got_t[i-1] !== 10) begin
        bad++;
        $display("FAIL rr_gap[%0d]: got %0d want 10",
                 i, got_t[i] - got_t[i-1]);
      end
    end
    motor_enable = 4'b1010;
    collect(4, 100);
    for (int i = 0; i < 4; i++) begin
      vec++;
      if (got_m[i] !== exp_b[i]) begin
        bad++;
        $display("FAIL mask_seq[%0d]: got %0d want %0d",
                 i, got_m[i], exp_b[i]);
      end
    end
    ov = int'(overrun_count);
    motor_enable = 4'b0000;
    collect(1, 40);
    resp_valid = 1'b0;
    vec++;
    if (ngot !== 0) begin
      bad++;
      $display("FAIL mask0_cmd: got %0d rises want 0", ngot);
    end
    vec++;
    if (int'(overrun_count) !== ov || overrun_count !== 16'd0) begin
      bad++;
      $display("FAIL mask0_ovr: got %0d want 0", overrun_count);
    end
    quality_sel = 8'd0;
    cyc();
    vec++;
    if (quality !== 8'd130) begin
      bad++;
      $display("FAIL rr_q0: got %0d want 130", quality);
    end
    quality_sel = 8'd1;
    cyc();
    vec++;
    if (quality !== 8'd131) begin
      bad++;
      $display("FAIL rr_q1: got %0d want 131", quality);
    end
    quality_sel = 8'd2;
    cyc();
    vec++;
    if (quality !== 8'd129) begin
      bad++;
      $display("FAIL rr_q2: got %0d want 129", quality);
    end
  endtask

  task automatic test_hold();
    int n;
    int unstable = 0;
    do_reset(32'd25, 4'b1111);
    wait_cv(40, n);
    vec++;
    if (n !== 12) begin
      bad++;
      $display("FAIL first_cmd_lat: got %0d want 12", n);
    end
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (cmd_valid !== 1'b1 || cmd_motor !== 8'd0) unstable++;
    end
    vec++;
    if (unstable !== 0) begin
      bad++;
      $display("FAIL hold_stable: got %0d bad cycles want 0", unstable);
    end
    cmd_ready = 1'b1;
    cyc();
    resp_valid = 1'b1;
    resp_motor = 8'd0;
    resp_crc_ok = 1'b1;
    cyc();
    resp_valid = 1'b0;
    vec++;
    if (overrun_count !== 16'd1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL hold_ovr: got ovr %0d busy %b want 1 0",
               overrun_count, busy);
    end
    cyc();
    vec++;
    if (cmd_valid !== 1'b1 || cmd_motor !== 8'd1) begin
      bad++;
      $display("FAIL hold_pending: got v %b m %0d want 1 1",
               cmd_valid, cmd_motor);
    end
  endtask

  task automatic start_one();
    int n;
    do_reset(32'd25, 4'b0001);
    cmd_ready = 1'b1;
    wait_cv(40, n);
    update_frequency_Hz = '0;
    cyc();
    vec++;
    if (busy !== 1'b1 || cmd_valid !== 1'b0) begin
      bad++;
      $display("FAIL handshake: got busy %b v %b want 1 0",
               busy, cmd_valid);
    end
  endtask

  task automatic test_timeout();
    int k;
    start_one();
    wait_to(40, k);
    vec++;
    if (k !== TO) begin
      bad++;
      $display("FAIL timeout_lat: got %0d want %0d", k, TO);
    end
`ifdef RETRY_EN
    vec++;
    if (cmd_valid !== 1'b1 || cmd_motor !== 8'd0) begin
      bad++;
      $display("FAIL retry_send: got v %b m %0d want 1 0",
               cmd_valid, cmd_motor);
    end
`endif
    cyc();
    vec++;
    if (timeout_pulse !== 1'b0) begin
      bad++;
      $display("FAIL timeout_width: got %b want 0", timeout_pulse);
    end
`ifdef RETRY_EN
    wait_to(40, k);
    vec++;
    if (k !== TO) begin
      bad++;
      $display("FAIL retry_timeout_lat: got %0d want %0d", k, TO);
    end
    cyc();
`endif
    quality_sel = 8'd0;
    cyc();
    vec++;
    if (busy !== 1'b0 || quality !== 8'd120) begin
      bad++;
      $display("FAIL timeout_score: got busy %b q %0d want 0 120",
               busy, quality);
    end
  endtask

  task automatic test_crc();
    start_one();
    resp_valid = 1'b1;
    resp_motor = 8'd2;
    resp_crc_ok = 1'b1;
    cyc();
    vec++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL wrong_id: got busy %b want 1", busy);
    end
    resp_motor = 8'd0;
    resp_crc_ok = 1'b0;
    cyc();
    resp_valid = 1'b0;
`ifdef RETRY_EN
    cyc();
    resp_valid = 1'b1;
    cyc();
    resp_valid = 1'b0;
`endif
    quality_sel = 8'd0;
    cyc();
    vec++;
    if (busy !== 1'b0 || quality !== 8'd120) begin
      bad++;
      $display("FAIL crc_score: got busy %b q %0d want 0 120",
               busy, quality);
    end
  endtask

  task automatic test_resp_vs_timeout();
    start_one();
    repeat (TO - 1) cyc();
    resp_valid = 1'b1;
    resp_motor = 8'd0;
    resp_crc_ok = 1'b1;
    cyc();
    resp_valid = 1'b0;
    vec++;
    if (timeout_pulse !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL race: got to %b busy %b want 0 0",
               timeout_pulse, busy);
    end
    quality_sel = 8'd0;
    cyc();
    vec++;
    if (timeout_pulse !== 1'b0 || quality !== 8'd129) begin
      bad++;
      $display("FAIL race_score: got to %b q %0d want 0 129",
               timeout_pulse, quality);
    end
  endtask

`ifdef RETRY_EN
  task automatic test_retry();
    int k;
    start_one();
    wait_to(40, k);
    vec++;
    if (cmd_valid !== 1'b1 || cmd_motor !== 8'd0) begin
      bad++;
      $display("FAIL retry_hs2: got v %b m %0d want 1 0",
               cmd_valid, cmd_motor);
    end
    cyc();
    resp_valid = 1'b1;
    resp_motor = 8'd0;
    resp_crc_ok = 1'b1;
    cyc();
    resp_valid = 1'b0;
    quality_sel = 8'd0;
    cyc();
    vec++;
    if (busy !== 1'b0 || quality !== 8'd129) begin
      bad++;
      $display("FAIL retry_score: got busy %b q %0d want 0 129",
               busy, quality);
    end
  endtask
`endif

  task automatic test_reset_midframe();
    start_one();
    reset = 1'b1;
    cyc();
    vec++;
    if ({cmd_valid, busy, timeout_pulse} !== 3'b000 ||
        current_motor !== 8'd3 || cmd_motor !== 8'd0 ||
        overrun_count !== 16'd0 || quality !== 8'd0) begin
      bad++;
      $display("FAIL mid_reset: got v%b b%b t%b cur %0d q %0d want 0 0 0 3 0",
               cmd_valid, busy, timeout_pulse, current_motor, quality);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_hold();
    test_timeout();
    test_crc();
    test_resp_vs_timeout();
`ifdef RETRY_EN
    test_retry();
`endif
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
